// File: rtl/pwm_duty_ramp.sv
// rtl/pwm_duty_ramp.sv - soft-start/soft-stop duty ramp controller for a left-aligned PWM generator
module pwm_duty_ramp #(
    parameter int K_RES = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_kill,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [K_RES-1:0] i_cmd_max,
    input  logic [K_RES-1:0] i_cmd_target,
    input  logic [K_RES-1:0] i_cmd_step,
    output logic             o_pwm_enable,
    output logic [K_RES-1:0] o_pwm_max,
    output logic [K_RES-1:0] o_pwm_threshold,
    output logic             o_period_tick,
    output logic             o_at_target,
    output logic [1:0]       o_state
);

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_RAMP = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    localparam logic [K_RES-1:0] L_ONE = K_RES'(1);

    logic [1:0]       r_state;
    logic             r_enable;
    logic [K_RES-1:0] r_max;
    logic [K_RES-1:0] r_thr;
    logic [K_RES-1:0] r_tgt;
    logic [K_RES-1:0] r_step;
    logic [K_RES-1:0] r_max_cfg;
    logic [K_RES-1:0] r_pcnt;
    logic [K_RES-1:0] r_pmax;

    logic             w_accept;
    logic             w_pe;
    logic [K_RES-1:0] w_cmd_step;
    logic [K_RES-1:0] w_tgt;
    logic [K_RES-1:0] w_step;
    logic [K_RES-1:0] w_maxc;
    logic [K_RES:0]   w_up;
    logic [K_RES:0]   w_dn;
    logic [K_RES-1:0] w_ramp_thr;
    logic [K_RES-1:0] w_stop_thr;

    assign o_cmd_ready     = (r_state != S_STOP);
    assign w_accept        = i_cmd_valid && o_cmd_ready;
    assign w_pe            = r_enable && (r_pcnt == r_pmax);
    assign o_period_tick   = w_pe;
    assign o_pwm_enable    = r_enable;
    assign o_pwm_max       = r_max;
    assign o_pwm_threshold = r_thr;
    assign o_state         = r_state;
    assign o_at_target     = (r_state == S_HOLD) && (r_thr == r_tgt);

    // A command accepted on the period-end edge must already steer that step.
    assign w_cmd_step = (i_cmd_step == '0) ? L_ONE : i_cmd_step;
    assign w_tgt      = w_accept ? i_cmd_target : r_tgt;
    assign w_step     = w_accept ? w_cmd_step   : r_step;
    assign w_maxc     = w_accept ? i_cmd_max    : r_max_cfg;

    assign w_up = {1'b0, r_thr} + {1'b0, w_step};
    assign w_dn = {1'b0, r_thr} - {1'b0, w_step};

    always_comb begin
        w_ramp_thr = r_thr;
        if (r_thr < w_tgt) begin
            w_ramp_thr = (w_up >= {1'b0, w_tgt}) ? w_tgt : w_up[K_RES-1:0];
        end else if (r_thr > w_tgt) begin
            w_ramp_thr = (w_dn[K_RES] || (w_dn[K_RES-1:0] <= w_tgt)) ? w_tgt : w_dn[K_RES-1:0];
        end
    end

    assign w_stop_thr = w_dn[K_RES] ? '0 : w_dn[K_RES-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tgt     <= '0;
            r_step    <= L_ONE;
            r_max_cfg <= '0;
        end else if (w_accept) begin
            r_tgt     <= i_cmd_target;
            r_step    <= w_cmd_step;
            r_max_cfg <= i_cmd_max;
        end
    end

    // Mirror of the generator counter; pmax survives disable just like the generator.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pcnt <= '0;
            r_pmax <= '0;
        end else if (r_enable) begin
            if (r_pcnt == '0) begin
                r_pmax <= r_max;
            end
            r_pcnt <= (r_pcnt == r_pmax) ? '0 : (r_pcnt + L_ONE);
        end else begin
            r_pcnt <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_OFF;
            r_enable <= 1'b0;
            r_max    <= '0;
            r_thr    <= '0;
        end else if (i_kill) begin
            r_state  <= S_OFF;
            r_enable <= 1'b0;
            r_thr    <= '0;
            r_max    <= w_maxc;
        end else begin
            case (r_state)
                S_OFF: begin
                    r_max <= w_maxc;
                    r_thr <= '0;
                    if (i_run) begin
                        r_state  <= S_RAMP;
                        r_enable <= 1'b1;
                    end
                end
                S_RAMP, S_HOLD: begin
                    if (!i_run) begin
                        r_state <= S_STOP;
                    end else if (w_pe) begin
                        r_thr   <= w_ramp_thr;
                        r_max   <= w_maxc;
                        r_state <= (w_ramp_thr == w_tgt) ? S_HOLD : S_RAMP;
                    end else if ((r_state == S_HOLD) && w_accept && (i_cmd_target != r_thr)) begin
                        r_state <= S_RAMP;
                    end
                end
                S_STOP: begin
                    if (i_run) begin
                        r_state <= S_RAMP;
                    end else if (w_pe) begin
                        r_max <= r_max_cfg;
                        if (r_thr == '0) begin
                            r_state  <= S_OFF;
                            r_enable <= 1'b0;
                        end else begin
                            r_thr <= w_stop_thr;
                        end
                    end
                end
                default: begin
                    r_state  <= S_OFF;
                    r_enable <= 1'b0;
                    r_thr    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb/tb_pwm_duty_ramp.sv - directed self-checking bench for pwm_duty_ramp with a generator counter model
module tb_pwm_duty_ramp;

    logic        clk;
    logic        rst_n;
    logic        i_run;
    logic        i_kill;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [15:0] i_cmd_max;
    logic [15:0] i_cmd_target;
    logic [15:0] i_cmd_step;
    logic        o_pwm_enable;
    logic [15:0] o_pwm_max;
    logic [15:0] o_pwm_threshold;
    logic        o_period_tick;
    logic        o_at_target;
    logic [1:0]  o_state;

    int total = 0;
    int bad   = 0;

    pwm_duty_ramp #(.K_RES(16)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_run           (i_run),
        .i_kill          (i_kill),
        .i_cmd_valid     (i_cmd_valid),
        .o_cmd_ready     (o_cmd_ready),
        .i_cmd_max       (i_cmd_max),
        .i_cmd_target    (i_cmd_target),
        .i_cmd_step      (i_cmd_step),
        .o_pwm_enable    (o_pwm_enable),
        .o_pwm_max       (o_pwm_max),
        .o_pwm_threshold (o_pwm_threshold),
        .o_period_tick   (o_period_tick),
        .o_at_target     (o_at_target),
        .o_state         (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference generator counter driven by the DUT's enable and max outputs.
    logic [15:0] g_cnt;
    logic [15:0] g_max;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_cnt <= 16'd0;
            g_max <= 16'd0;
        end else if (o_pwm_enable) begin
            if (g_cnt == 16'd0) g_max <= o_pwm_max;
            g_cnt <= (g_cnt == g_max) ? 16'd0 : g_cnt + 16'd1;
        end else begin
            g_cnt <= 16'd0;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("lockstep_cnt", {16'd0, dut.r_pcnt}, {16'd0, g_cnt});
            check("tick_vs_gen", {31'd0, o_period_tick}, {31'd0, (o_pwm_enable && (g_cnt == g_max))});
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        i_run = 1'b0;
        i_kill = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_max = 16'd0;
        i_cmd_target = 16'd0;
        i_cmd_step = 16'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_cmd(input logic [15:0] mx, input logic [15:0] tg, input logic [15:0] st);
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd_max = mx;
        i_cmd_target = tg;
        i_cmd_step = st;
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    // Returns just after the period-end edge; n = cycles waited including the pe cycle.
    task automatic wait_pe(input int limit, output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (o_period_tick) break;
            if (n >= limit) begin
                total++;
                bad++;
                $display("FAIL pe_timeout: got no tick after %0d cycles want tick", n);
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] mx;
        logic [15:0] tg;
        logic [15:0] st;
        int          n;
        logic [47:0] ex;
        int          per;
    } vec_t;

    vec_t vt[4];
    int   n;

    initial begin
        vt[0] = '{16'd9, 16'd5, 16'd4, 2, {16'd0, 16'd5, 16'd4},     10};
        vt[1] = '{16'd3, 16'd3, 16'd0, 3, {16'd3, 16'd2, 16'd1},     4};
        vt[2] = '{16'd2, 16'd7, 16'd3, 3, {16'd7, 16'd6, 16'd3},     3};
        vt[3] = '{16'd9, 16'd6, 16'd2, 3, {16'd6, 16'd4, 16'd2},     10};

        do_reset();
        @(negedge clk);
        check("rst_state",  {30'd0, o_state}, 32'd0);
        check("rst_enable", {31'd0, o_pwm_enable}, 32'd0);
        check("rst_max",    {16'd0, o_pwm_max}, 32'd0);
        check("rst_thr",    {16'd0, o_pwm_threshold}, 32'd0);
        check("rst_tick",   {31'd0, o_period_tick}, 32'd0);
        check("rst_attgt",  {31'd0, o_at_target}, 32'd0);
        check("rst_ready",  {31'd0, o_cmd_ready}, 32'd1);

        for (int v = 0; v < 4; v++) begin
            do_reset();
            send_cmd(vt[v].mx, vt[v].tg, vt[v].st);
            check("en_before_run", {31'd0, o_pwm_enable}, 32'd0);
            i_run = 1'b1;
            @(posedge clk);
            #1;
            check("en_rise", {31'd0, o_pwm_enable}, 32'd1);
            check("first_tick_degenerate", {31'd0, o_period_tick}, 32'd1);
            for (int k = 0; k < vt[v].n; k++) begin
                wait_pe(200, n);
                check("ramp_thr", {16'd0, o_pwm_threshold}, {16'd0, vt[v].ex[k*16 +: 16]});
                if (k == 1) check("period_len", n, vt[v].per);
            end
            check("hold_state", {30'd0, o_state}, 32'd2);
            check("hold_attgt", {31'd0, o_at_target}, 32'd1);
            check("hold_max", {16'd0, o_pwm_max}, {16'd0, vt[v].mx});
        end

        // Soft stop from HOLD thr=6 step=2.
        @(negedge clk);
        i_run = 1'b0;
        @(posedge clk);
        #1;
        check("stop_state", {30'd0, o_state}, 32'd3);
        check("stop_ready", {31'd0, o_cmd_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            wait_pe(200, n);
            check("stop_thr", {16'd0, o_pwm_threshold}, 32'(4 - 2 * k));
            check("stop_ready_ramp", {31'd0, o_cmd_ready}, 32'd0);
        end
        check("stop_still_en", {31'd0, o_pwm_enable}, 32'd1);
        wait_pe(200, n);
        check("stop_off_state", {30'd0, o_state}, 32'd0);
        check("stop_off_en", {31'd0, o_pwm_enable}, 32'd0);

        // Restart (pmax kept at 9), then resume during STOP at thr=4.
        @(negedge clk);
        i_run = 1'b1;
        for (int k = 0; k < 3; k++) wait_pe(200, n);
        check("restart_thr", {16'd0, o_pwm_threshold}, 32'd6);
        check("restart_hold", {30'd0, o_state}, 32'd2);
        @(negedge clk);
        i_run = 1'b0;
        wait_pe(200, n);
        check("resume_stop_thr", {16'd0, o_pwm_threshold}, 32'd4);
        @(negedge clk);
        i_run = 1'b1;
        @(posedge clk);
        #1;
        check("resume_ramp", {30'd0, o_state}, 32'd1);
        wait_pe(200, n);
        check("resume_thr", {16'd0, o_pwm_threshold}, 32'd6);
        check("resume_hold", {30'd0, o_state}, 32'd2);

        // Retarget to 3 with the command landing on the period-end edge.
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (o_period_tick || n > 200) break;
        end
        i_cmd_valid = 1'b1;
        i_cmd_max = 16'd9;
        i_cmd_target = 16'd3;
        i_cmd_step = 16'd2;
        @(posedge clk);
        #1;
        check("coinc_thr", {16'd0, o_pwm_threshold}, 32'd4);
        check("coinc_ramp", {30'd0, o_state}, 32'd1);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        wait_pe(200, n);
        check("retgt_thr", {16'd0, o_pwm_threshold}, 32'd3);
        check("retgt_hold", {30'd0, o_state}, 32'd2);
        check("retgt_attgt", {31'd0, o_at_target}, 32'd1);

        // Max changes 9 -> 3 -> 0 while the lockstep monitor watches.
        send_cmd(16'd3, 16'd3, 16'd2);
        check("max3_stays_hold", {30'd0, o_state}, 32'd2);
        wait_pe(200, n);
        check("max3_out", {16'd0, o_pwm_max}, 32'd3);
        wait_pe(200, n);
        check("max3_period", n, 32'd4);
        send_cmd(16'd0, 16'd3, 16'd2);
        wait_pe(200, n);
        check("max0_out", {16'd0, o_pwm_max}, 32'd0);
        wait_pe(70000, n);
        check("max0_wrap_period", n, 32'd65537);
        wait_pe(10, n);
        check("max0_period", n, 32'd1);

        // Down ramp 0xFFF0 -> 0 by 0x20 with 1-cycle periods; must never wrap.
        do_reset();
        send_cmd(16'd0, 16'hFFF0, 16'hFFFF);
        i_run = 1'b1;
        @(posedge clk);
        #1;
        wait_pe(10, n);
        check("big_up_thr", {16'd0, o_pwm_threshold}, 32'hFFF0);
        check("big_up_hold", {30'd0, o_state}, 32'd2);
        begin
            logic [15:0] prev;
            int          changes;
            int          mono;
            prev = 16'hFFF0;
            changes = 0;
            mono = 1;
            @(negedge clk);
            i_cmd_valid = 1'b1;
            i_cmd_max = 16'd0;
            i_cmd_target = 16'd0;
            i_cmd_step = 16'h0020;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                i_cmd_valid = 1'b0;
                if (o_pwm_threshold != prev) begin
                    changes++;
                    if (o_pwm_threshold > prev) mono = 0;
                    prev = o_pwm_threshold;
                end
                if (o_state == 2'd2 && o_pwm_threshold == 16'd0) break;
            end
            check("down_steps", changes, 32'd2048);
            check("down_nowrap", mono, 32'd1);
            check("down_final_thr", {16'd0, o_pwm_threshold}, 32'd0);
            check("down_final_hold", {30'd0, o_state}, 32'd2);
        end

        // Kill mid-RAMP.
        do_reset();
        send_cmd(16'd9, 16'd6, 16'd2);
        i_run = 1'b1;
        @(posedge clk);
        #1;
        wait_pe(10, n);
        check("kill_pre_thr", {16'd0, o_pwm_threshold}, 32'd2);
        repeat (3) @(negedge clk);
        i_kill = 1'b1;
        @(posedge clk);
        #1;
        check("kill_state", {30'd0, o_state}, 32'd0);
        check("kill_en", {31'd0, o_pwm_enable}, 32'd0);
        check("kill_thr", {16'd0, o_pwm_threshold}, 32'd0);
        @(posedge clk);
        #1;
        check("kill_beats_run", {30'd0, o_state}, 32'd0);
        @(negedge clk);
        i_kill = 1'b0;
        i_run = 1'b0;

        // Asynchronous reset mid-HOLD.
        do_reset();
        send_cmd(16'd1, 16'd2, 16'd2);
        i_run = 1'b1;
        @(posedge clk);
        #1;
        wait_pe(10, n);
        check("arst_pre_hold", {30'd0, o_state}, 32'd2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state",  {30'd0, o_state}, 32'd0);
        check("arst_en",     {31'd0, o_pwm_enable}, 32'd0);
        check("arst_max",    {16'd0, o_pwm_max}, 32'd0);
        check("arst_thr",    {16'd0, o_pwm_threshold}, 32'd0);
        check("arst_tick",   {31'd0, o_period_tick}, 32'd0);
        check("arst_attgt",  {31'd0, o_at_target}, 32'd0);
        check("arst_ready",  {31'd0, o_cmd_ready}, 32'd1);
        i_run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ramp.md
# pwm_duty_ramp

Soft-start/soft-stop controller for the single-channel left-aligned PWM generator. It drives the generator's enable, period (max) and threshold inputs. The duty cycle ramps by a programmable step once per PWM period toward a commanded target. When run is removed, the duty ramps back to zero before the generator is disabled. An internal period counter mirrors the generator, so every threshold change lands exactly on the generator's cnt==0 reload.

## Interface
- K_RES, 16, width of counter, max and threshold values (matches generator)
- i_clk  in  1  master clock
- i_rst_n  in  1  asynchronous active-low reset
- i_run  in  1  level; 1 = run at target duty, 0 = ramp down and stop
- i_kill  in  1  immediate shutdown, no ramp
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command ready
- i_cmd_max  in  K_RES  new PWM period value (period = max+1 cycles)
- i_cmd_target  in  K_RES  new target threshold
- i_cmd_step  in  K_RES  threshold increment per period (0 treated as 1)
- o_pwm_enable  out  1  to generator i_enable
- o_pwm_max  out  K_RES  to generator i_max
- o_pwm_threshold  out  K_RES  to generator i_threshold
- o_period_tick  out  1  1-cycle pulse on last cycle of each PWM period
- o_at_target  out  1  threshold == target in HOLD
- o_state  out  2  OFF=0, RAMP=1, HOLD=2, STOP=3

## Operation
- Registers: tgt, step, max_cfg (command shadow); pcnt, pmax (generator mirror); state.
- Mirror: pmax reset 0, never cleared by disable. While enabled and pcnt==0: pmax<=o_pwm_max. pcnt<=(pcnt==pmax)?0:pcnt+1 while enabled, 0 while disabled. This is bit-identical to the generator's counter.
- Period end (pe) = o_pwm_enable && pcnt==pmax; o_period_tick = pe (registered-equivalent, combinational from regs).
- Command: handshake when i_cmd_valid && o_cmd_ready. o_cmd_ready = 1 in OFF, RAMP, HOLD; 0 in STOP. On accept: tgt, step (0→1), max_cfg load; takes effect at next pe (immediately in OFF).
- OFF: enable=0, threshold=0, o_pwm_max=max_cfg. If i_run && !i_kill → RAMP, enable<=1.
- RAMP: on pe, threshold moves toward tgt by step. Up: min(thr+step, tgt). Down: max(thr−step, tgt). Compute in K_RES+1 bits, no wrap, no overshoot. o_pwm_max<=max_cfg on pe. New threshold == tgt → HOLD.
- HOLD: threshold constant; o_at_target=1. Accepted command with tgt≠threshold → RAMP (applied from next pe).
- Any of RAMP/HOLD with i_run=0 → STOP. STOP ramps threshold down by step on pe, saturating at 0. On the pe where threshold is already 0 → OFF, enable<=0.
- STOP with i_run=1 → RAMP (resume from current threshold toward tgt).
- i_kill=1 in any state: next edge OFF, enable=0, threshold=0; has priority over all else.
- Threshold > max is legal (generator outputs 100% duty); not clamped.

## Timing
- Reset: state=OFF, o_pwm_enable=0, o_pwm_max=0, o_pwm_threshold=0, o_period_tick=0, o_at_target=0, o_cmd_ready=1, tgt=0, step=1, max_cfg=0, pcnt=0, pmax=0.
- OFF→RAMP: enable rises 1 cycle after i_run sampled high. The first period is degenerate (pmax=0 → 1 cycle), as in the generator.
- Threshold/max update registered on pe edge → visible when pcnt==0 → generator latches them on that cycle; applies from the following period.
- i_run/i_kill sampled every cycle; state changes take 1 cycle; ramp steps only on pe.
- Command accepted on same edge as pe: new values used at that pe.
- Reset mid-operation: immediate return to reset values regardless of state.

## Test plan
- Soft start: cmd max=9, target=6, step=2, i_run=1 → threshold 0,2,4,6 on successive pe (period 10 cycles after the first). HOLD and o_at_target=1 after 3rd ramp pe. Generator high-time matches threshold each period.
- Saturation: target=5, step=4 → 0,4,5 (no overshoot). Step=0 → increments of 1. Down ramp from 0xFFF0 with step 0x20 to target 0 → no wrap, ends at 0.
- Soft stop: from HOLD thr=6, step=2, i_run=0 → STOP, 4,2,0, then OFF at next pe with enable=0. Cmd ready=0 throughout STOP.
- Resume/retarget: i_run toggled 0→1 during STOP at thr=4 → RAMP back up to 6. Command target=3 in HOLD → ramp down to 3. Command coinciding with pe is applied at that pe.
- Kill and reset: i_kill mid-RAMP → OFF next cycle, enable=0, thr=0. i_rst_n low mid-HOLD → all outputs to reset values asynchronously.
- Lockstep check: bench instantiates the generator and asserts pcnt == generator cnt every cycle across max changes 9→3→0.
